fetch_stage_bp: RTL and testbench
=================================

Name: fetch_stage_bp

Overview:
Parametrised instruction-fetch stage with integrated branch prediction: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It holds the PC, drives the instruction-memory address and registers the IF/ID pipeline outputs. It predicts taken branches in the fetch cycle, accepts training and mispredict redirects from execute, and honours stall and flush from the hazard unit. It replaces the fixed PC+4 fetch stage in the pipelined core.

Parameters:
XLEN, 32, PC and instruction width
BTB_ENTRIES, 16, BTB entries (power of two, >=2); IDX_W = log2(BTB_ENTRIES)
RESET_PC, 32'h0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  reset
imem_addr  out  XLEN  fetch address (= pc_f)
imem_rdata  in  XLEN  instruction from combinational instruction memory
stall_f  in  1  hold PC
stall_d  in  1  hold IF/ID register
flush_d  in  1  clear IF/ID register
redirect_en  in  1  execute-stage mispredict; fetch must restart at redirect_pc
redirect_pc  in  XLEN  correct next PC
upd_en  in  1  resolved control-flow instruction in execute (BTB training)
upd_pc  in  XLEN  PC of the resolved instruction
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual taken target
instr_d  out  XLEN  IF/ID instruction
pc_d  out  XLEN  IF/ID PC
pcplus4_d  out  XLEN  IF/ID PC+4
pred_taken_d  out  1  prediction made for instr_d
pred_target_d  out  XLEN  predicted target (0 when not predicted taken)
valid_d  out  1  IF/ID holds a real instruction

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - pc_f = RESET_PC.
  - All IF/ID outputs = 0, including valid_d = 0.
  - All BTB valid bits cleared; all counters = 2'b01 (weakly not-taken).
  - Reset mid-operation discards all state immediately.
- Lookup (combinational on pc_f):
  - idx = pc_f[IDX_W+1:2]; tag = pc_f[XLEN-1:IDX_W+2].
  - hit = valid[idx] && tag match.
  - pred_taken_f = hit && ctr[idx][1]; pred_target_f = pred_taken_f ? target[idx] : 0.
- Next-PC priority, evaluated each clock edge:
  1. redirect_en -> pc_f <= redirect_pc (overrides stall_f).
  2. stall_f -> hold.
  3. pred_taken_f -> pred_target_f.
  4. otherwise pc_f + 4 (wraps modulo 2^XLEN).
- IF/ID register priority:
  1. flush_d or redirect_en -> all outputs cleared to 0, valid_d = 0 (flush wins over stall_d).
  2. stall_d -> hold.
  3. otherwise latch imem_rdata, pc_f, pc_f+4, pred_taken_f, pred_target_f; valid_d = 1.
- BTB update on upd_en, using idx/tag from upd_pc:
  - taken, entry hit: target <= upd_target; ctr saturating-increments (max 2'b11).
  - taken, entry miss: allocate/replace; valid <= 1, tag written, target <= upd_target, ctr <= 2'b10.
  - not taken, entry hit: ctr saturating-decrements (min 2'b00); valid/target unchanged.
  - not taken, entry miss: no change.
- Update is written at the clock edge. A same-cycle lookup of the same index sees the pre-update contents.
- Update is independent of stall/flush and proceeds while stalled.
- Latency: one cycle from pc_f to IF/ID outputs. Predicted redirect has zero bubbles; mispredict costs the flushed IF/ID slot plus the execute-side flush.
- No internal state besides pc_f, the IF/ID register and the BTB arrays (valid, tag, target, ctr).

Test Plan:
- Reset then 4 free-running cycles, imem returns 32'h00000013 -> pc_d sequence 0,4,8 with valid_d=1; before the first edge after reset all outputs are 0.
- Train: upd_en, upd_pc=0x10, upd_taken=1, upd_target=0x40, then fetch reaches 0x10 -> pred_taken_d=1, pred_target_d=0x40, and the next pc_d is 0x40 with no bubble.
- Two not-taken updates on 0x10 after the step above (ctr 10->01->00) -> fetch at 0x10 predicts not taken; next pc_d is 0x14.
- Aliasing with BTB_ENTRIES=16: train 0x10, then fetch 0x50 (same idx, different tag) -> no prediction, next PC 0x54.
- redirect_en with redirect_pc=0x80 while stall_f=1 and stall_d=1 -> next cycle valid_d=0 and pc_f=0x80; the cycle after, pc_d=0x80.
- stall_d and flush_d asserted together -> IF/ID cleared; stall_f alone -> pc_f held and imem_addr constant; assert rst mid-stream -> outputs 0 immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_bp_if.sv
// Fetch-stage bus: instruction-memory port, hazard controls, execute-side
// redirect/training inputs and the IF/ID pipeline outputs.
//   master : the fetch stage (drives imem_addr and the *_d outputs)
//   slave  : the surrounding core (drives imem_rdata, hazards, redirect, update)
interface fetch_stage_bp_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_en;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pcplus4_d;
  logic            pred_taken_d;
  logic [XLEN-1:0] pred_target_d;
  logic            valid_d;

  modport master (
    output imem_addr, instr_d, pc_d, pcplus4_d, pred_taken_d, pred_target_d, valid_d,
    input  imem_rdata, stall_f, stall_d, flush_d, redirect_en, redirect_pc,
           upd_en, upd_pc, upd_taken, upd_target
  );

  modport slave (
    input  imem_addr, instr_d, pc_d, pcplus4_d, pred_taken_d, pred_target_d, valid_d,
    output imem_rdata, stall_f, stall_d, flush_d, redirect_en, redirect_pc,
           upd_en, upd_pc, upd_taken, upd_target
  );
endinterface

// File: rtl/fetch_stage_bp.sv
// Instruction-fetch stage with a direct-mapped BTB and 2-bit saturating
// counters. Holds pc_f, drives imem_addr, registers IF/ID outputs.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_stage_bp_if.master (imem port, hazards, redirect,
//              BTB training, IF/ID outputs)
module fetch_stage_bp #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_bp_if.master bus
);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcPlus4F;

  logic [XLEN-1:0] instrD, pcD, pcPlus4D, predTargetD;
  logic            predTakenD, validD;

  logic [BTB_ENTRIES-1:0] btbValid;
  logic [TAG_W-1:0]       btbTag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btbTarget [BTB_ENTRIES];
  logic [1:0]             btbCtr    [BTB_ENTRIES];

  logic [IDX_W-1:0] fIdx, uIdx;
  logic [TAG_W-1:0] fTag, uTag;
  logic             fHit, uHit;
  logic             predTakenF;
  logic [XLEN-1:0]  predTargetF;
  logic             unused_updLsb;

  // Fetch-side lookup and training-side lookup (both on pre-update contents)
  assign fIdx = pcF[IDX_W+1:2];
  assign fTag = pcF[XLEN-1:IDX_W+2];
  assign uIdx = bus.upd_pc[IDX_W+1:2];
  assign uTag = bus.upd_pc[XLEN-1:IDX_W+2];
  assign unused_updLsb = ^bus.upd_pc[1:0];

  assign fHit        = btbValid[fIdx] && (btbTag[fIdx] == fTag);
  assign uHit        = btbValid[uIdx] && (btbTag[uIdx] == uTag);
  assign predTakenF  = fHit && btbCtr[fIdx][1];
  assign predTargetF = predTakenF ? btbTarget[fIdx] : '0;
  assign pcPlus4F    = pcF + FOUR;

  // PC register: redirect beats stall, then prediction, then sequential
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF <= RESET_PC;
    end else if (bus.redirect_en) begin
      pcF <= bus.redirect_pc;
    end else if (!bus.stall_f) begin
      pcF <= predTakenF ? predTargetF : pcPlus4F;
    end
  end

  // IF/ID register: a mispredict redirect also squashes the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instrD      <= '0;
      pcD         <= '0;
      pcPlus4D    <= '0;
      predTakenD  <= 1'b0;
      predTargetD <= '0;
      validD      <= 1'b0;
    end else if (bus.flush_d || bus.redirect_en) begin
      instrD      <= '0;
      pcD         <= '0;
      pcPlus4D    <= '0;
      predTakenD  <= 1'b0;
      predTargetD <= '0;
      validD      <= 1'b0;
    end else if (!bus.stall_d) begin
      instrD      <= bus.imem_rdata;
      pcD         <= pcF;
      pcPlus4D    <= pcPlus4F;
      predTakenD  <= predTakenF;
      predTargetD <= predTargetF;
      validD      <= 1'b1;
    end
  end

  // BTB training; runs regardless of stall/flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btbValid <= '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        btbTag[IDX_W'(i)]    <= '0;
        btbTarget[IDX_W'(i)] <= '0;
        btbCtr[IDX_W'(i)]    <= 2'b01;
      end
    end else if (bus.upd_en) begin
      if (bus.upd_taken) begin
        btbTarget[uIdx] <= bus.upd_target;
        if (uHit) begin
          if (btbCtr[uIdx] != 2'b11) btbCtr[uIdx] <= btbCtr[uIdx] + 2'd1;
        end else begin
          btbValid[uIdx] <= 1'b1;
          btbTag[uIdx]   <= uTag;
          btbCtr[uIdx]   <= 2'b10;
        end
      end else if (uHit && (btbCtr[uIdx] != 2'b00)) begin
        btbCtr[uIdx] <= btbCtr[uIdx] - 2'd1;
      end
    end
  end

  assign bus.imem_addr     = pcF;
  assign bus.instr_d       = instrD;
  assign bus.pc_d          = pcD;
  assign bus.pcplus4_d     = pcPlus4D;
  assign bus.pred_taken_d  = predTakenD;
  assign bus.pred_target_d = predTargetD;
  assign bus.valid_d       = validD;
endmodule

// File: tb/tb_fetch_stage_bp.sv
// Testbench for fetch_stage_bp: directed scenarios plus randomized traffic,
// with expected IF/ID state queued by the driver and checked by a monitor.
module tb_fetch_stage_bp;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam logic [31:0] RST_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_bp_if #(.XLEN(XLEN)) bus ();

  fetch_stage_bp #(.XLEN(XLEN), .BTB_ENTRIES(ENTRIES), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  assign bus.imem_rdata = imemWord(bus.imem_addr);

  typedef struct {
    logic [31:0] instr, pc, pcp4, ptgt, addr;
    logic        pt, valid;
  } exp_t;

  exp_t q[$];
  int nChecks = 0;
  int nPass   = 0;

  // Reference model: fetch PC, IF/ID contents and a map of trained branches
  logic [31:0] mPc;
  exp_t        mIfid;
  int          mStr [int];   // entry present <=> valid; value = counter strength 0..3
  logic [31:0] mTag [int];   // upper PC bits of the owning branch
  logic [31:0] mTgt [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mPc   = RST_PC;
    mIfid = '{default: 0};
    mStr.delete();
    mTag.delete();
    mTgt.delete();
  endtask

  // Drive one cycle of inputs at the falling edge, queue the expected result
  task automatic step(input logic sf, input logic sd, input logic fl,
                      input logic rd, input logic [31:0] rpc,
                      input logic ue, input logic ut,
                      input logic [31:0] upc, input logic [31:0] utg);
    int          fi, ui;
    logic [31:0] ftag, utag;
    bit          fhit, uhit, pt;
    logic [31:0] ptgt;
    exp_t        nx;
    bus.stall_f = sf; bus.stall_d = sd; bus.flush_d = fl;
    bus.redirect_en = rd; bus.redirect_pc = rpc;
    bus.upd_en = ue; bus.upd_taken = ut; bus.upd_pc = upc; bus.upd_target = utg;

    fi   = int'((mPc / 4) % ENTRIES);
    ftag = mPc / (4 * ENTRIES);
    fhit = mStr.exists(fi) && (mTag[fi] == ftag);
    pt   = fhit && (mStr[fi] >= 2);
    ptgt = pt ? mTgt[fi] : 32'h0;

    if (fl || rd) nx = '{default: 0};
    else if (sd) nx = mIfid;
    else begin
      nx.instr = imemWord(mPc);
      nx.pc    = mPc;
      nx.pcp4  = mPc + 32'd4;
      nx.pt    = pt;
      nx.ptgt  = ptgt;
      nx.valid = 1'b1;
    end

    if (rd)      mPc = rpc;
    else if (sf) mPc = mPc;
    else if (pt) mPc = ptgt;
    else         mPc = mPc + 32'd4;

    if (ue) begin
      ui   = int'((upc / 4) % ENTRIES);
      utag = upc / (4 * ENTRIES);
      uhit = mStr.exists(ui) && (mTag[ui] == utag);
      if (ut) begin
        mTgt[ui] = utg;
        if (uhit) mStr[ui] = (mStr[ui] < 3) ? mStr[ui] + 1 : 3;
        else begin
          mStr[ui] = 2;
          mTag[ui] = utag;
        end
      end else if (uhit) begin
        mStr[ui] = (mStr[ui] > 0) ? mStr[ui] - 1 : 0;
      end
    end

    mIfid   = nx;
    nx.addr = mPc;
    q.push_back(nx);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor: every cycle the DUT presents fresh IF/ID state after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_imem_addr", bus.imem_addr, e.addr);
        chk("sb_instr_d", bus.instr_d, e.instr);
        chk("sb_pc_d", bus.pc_d, e.pc);
        chk("sb_pcplus4_d", bus.pcplus4_d, e.pcp4);
        chk("sb_pred_taken_d", 32'(bus.pred_taken_d), 32'(e.pt));
        chk("sb_pred_target_d", bus.pred_target_d, e.ptgt);
        chk("sb_valid_d", 32'(bus.valid_d), 32'(e.valid));
      end
    end
  end

  initial begin
    logic        sf, sd, fl, rd, ue, ut;
    logic [31:0] rpc, upc, utg;
    rst = 1'b0;
    bus.stall_f = 0; bus.stall_d = 0; bus.flush_d = 0;
    bus.redirect_en = 0; bus.redirect_pc = 0;
    bus.upd_en = 0; bus.upd_taken = 0; bus.upd_pc = 0; bus.upd_target = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_imem_addr", bus.imem_addr, RST_PC);
    chk("rst_pc_d", bus.pc_d, 32'h0);
    chk("rst_instr_d", bus.instr_d, 32'h0);
    chk("rst_valid_d", 32'(bus.valid_d), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // Free-running sequential fetch
    idle(); chk("seq0_pc_d", bus.pc_d, 32'h0); chk("seq0_valid", 32'(bus.valid_d), 32'h1);
    idle(); chk("seq1_pc_d", bus.pc_d, 32'h4);
    idle(); chk("seq2_pc_d", bus.pc_d, 32'h8);

    // Train 0x10 -> 0x40, then predicted redirect with no bubble
    step(0, 0, 0, 0, 32'h0, 1, 1, 32'h10, 32'h40);
    idle();
    chk("pred_pc_d", bus.pc_d, 32'h10);
    chk("pred_taken_d", 32'(bus.pred_taken_d), 32'h1);
    chk("pred_target_d", bus.pred_target_d, 32'h40);
    idle(); chk("pred_next_pc_d", bus.pc_d, 32'h40);

    // Two not-taken updates weaken the counter to strongly not-taken
    step(0, 0, 0, 0, 32'h0, 1, 0, 32'h10, 32'h0);
    step(0, 0, 0, 0, 32'h0, 1, 0, 32'h10, 32'h0);
    step(0, 0, 0, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    idle();
    chk("nt_pc_d", bus.pc_d, 32'h10);
    chk("nt_pred_taken_d", 32'(bus.pred_taken_d), 32'h0);
    idle(); chk("nt_next_pc_d", bus.pc_d, 32'h14);

    // Aliasing: 0x50 shares the index of 0x10 but not the tag
    step(0, 0, 0, 0, 32'h0, 1, 1, 32'h10, 32'h40);
    step(0, 0, 0, 0, 32'h0, 1, 1, 32'h10, 32'h40);
    step(0, 0, 0, 1, 32'h50, 0, 0, 32'h0, 32'h0);
    idle();
    chk("alias_pc_d", bus.pc_d, 32'h50);
    chk("alias_pred_taken_d", 32'(bus.pred_taken_d), 32'h0);
    idle(); chk("alias_next_pc_d", bus.pc_d, 32'h54);

    // Redirect overrides both stalls
    step(1, 1, 0, 1, 32'h80, 0, 0, 32'h0, 32'h0);
    chk("redir_valid_d", 32'(bus.valid_d), 32'h0);
    chk("redir_imem_addr", bus.imem_addr, 32'h80);
    idle(); chk("redir_pc_d", bus.pc_d, 32'h80);

    // Flush wins over stall_d; stall_f holds the fetch address
    step(0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("flush_valid_d", 32'(bus.valid_d), 32'h0);
    chk("flush_pc_d", bus.pc_d, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("stallf_imem_addr0", bus.imem_addr, 32'h88);
    step(1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("stallf_imem_addr1", bus.imem_addr, 32'h88);
    chk("stallf_pc_d", bus.pc_d, 32'h88);

    // Randomized traffic over a small address window to force hits/aliases
    for (int i = 0; i < 1500; i++) begin
      sf  = ($urandom_range(0, 99) < 15);
      sd  = ($urandom_range(0, 99) < 15);
      fl  = ($urandom_range(0, 99) < 8);
      rd  = ($urandom_range(0, 99) < 10);
      ue  = ($urandom_range(0, 99) < 40);
      ut  = ($urandom_range(0, 99) < 60);
      rpc = 32'($urandom_range(0, 63)) * 32'd4 + (($urandom_range(0, 3) == 0) ? 32'h40 : 32'h0);
      if ($urandom_range(0, 1) == 1) upc = mPc + 32'($urandom_range(0, 3)) * 32'd4;
      else upc = 32'($urandom_range(0, 127)) * 32'd4;
      utg = 32'($urandom_range(0, 127)) * 32'd4;
      step(sf, sd, fl, rd, rpc, ue, ut, upc, utg);
    end

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("midrst_imem_addr", bus.imem_addr, RST_PC);
    chk("midrst_valid_d", 32'(bus.valid_d), 32'h0);
    chk("midrst_pc_d", bus.pc_d, 32'h0);
    chk("midrst_pred_target_d", bus.pred_target_d, 32'h0);
    bus.stall_f = 0; bus.stall_d = 0; bus.flush_d = 0;
    bus.redirect_en = 0; bus.upd_en = 0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    idle(); chk("restart_pc_d0", bus.pc_d, RST_PC);
    idle(); chk("restart_pc_d1", bus.pc_d, RST_PC + 32'd4);

    @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
